frame_disassembly: RTL and testbench
====================================

FRAME_DISASSEMBLY -- requirements
Module: frame_disassembly

Interface
REQ-001 Parameter GAP_MAX, default 4: maximum consecutive idle cycles (i_rvalid low) tolerated inside a frame.
REQ-002 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_rdata  input  8  received MHP byte.
REQ-006 i_rvalid  input  1  i_rdata valid this cycle; byte accepted unconditionally (no backpressure).
REQ-007 o_dst  output  16  destination address.
REQ-008 o_src  output  16  source address.
REQ-009 o_size  output  16  payload size field.
REQ-010 o_dir  output  1  direction bit.
REQ-011 o_type  output  7  frame type.
REQ-012 o_payload  output  336  payload, LSB = first payload byte.
REQ-013 o_frame_valid  output  1  one-cycle pulse: frame complete, checksum good.
REQ-014 o_frame_err  output  1  one-cycle pulse: checksum mismatch, gap timeout or size > 42.
REQ-015 o_busy  output  1  high while a frame is in progress.

Function
REQ-016 Frame = 51 bytes, little-endian per field: bytes 0-1 dst, 2-3 src, 4-5 size, 6 = {type[6:0], dir} (dir = bit 0), 7-48 payload[7:0] first, 49-50 scs low then high.
REQ-017 SCS = 16-bit modular sum over bytes k=0..48 of (byte_k zero-extended to 16 bits << (k mod 4)); a 2-bit shift counter starts at 0 at byte 0 and wraps 3->0.
REQ-018 States: IDLE, RECV, CHECK. IDLE->RECV on first accepted byte, which is byte 0. RECV->CHECK on acceptance of byte 50. CHECK->IDLE after one cycle.
REQ-019 Byte counter (6 bits) holds the index of the next expected byte; it increments only on accepted bytes.
REQ-020 Field registers are written as bytes arrive into an internal shadow; outputs o_dst..o_payload update only in CHECK and only when the frame is good; otherwise the outputs hold the previous good frame.
REQ-021 In CHECK, exactly one of the two pulses is asserted: o_frame_valid if the computed SCS equals the received SCS and size <= 42; otherwise o_frame_err.
REQ-022 Latency: the pulse is asserted in the cycle after byte 50 is accepted.
REQ-023 Gap counter counts consecutive RECV cycles with i_rvalid low and clears on any accepted byte.
REQ-024 When the gap count reaches GAP_MAX + 1, the block pulses o_frame_err, returns to IDLE, and discards the partial frame.
REQ-025 In CHECK, i_rvalid is ignored and the byte is dropped; a frame may start again in the following IDLE cycle.
REQ-026 o_busy is high in RECV and CHECK and low in IDLE.

Reset
REQ-027 Reset drives state IDLE; all counters, SCS, shadow and output fields 0; o_frame_valid, o_frame_err and o_busy 0.
REQ-028 Reset mid-frame aborts the frame with no pulse; the first byte accepted after release is treated as byte 0.

Structure
REQ-029 Shared package mhp_pkg holds MHP_FRAME_LEN=51, field byte offsets, PAYLOAD_BYTES=42 and the state encodings; the transmitter uses the same package.
REQ-030 Sub-module mhp_scs_accum (byte in, enable, clear, 16-bit sum out) implements REQ-017 and is reused by the transmitter.

Verification
REQ-031 All-zero 51-byte frame, contiguous -> o_frame_valid at cycle 52 after byte 0; all fields 0.
REQ-032 dst=0x0001, src=0x8000, all other bytes 0 -> SCS = 0x0001 + (0x80<<3) = 0x0401; bytes 49-50 = 0x01, 0x04 -> o_frame_valid, o_dst=0x0001, o_src=0x8000.
REQ-033 Same frame with byte 50 = 0x05 -> o_frame_err pulse; outputs keep the prior frame values.
REQ-034 Valid frame with 4 idle cycles after byte 20 -> o_frame_valid; with 5 idle cycles -> o_frame_err, o_busy low; the next frame decodes correctly.
REQ-035 size=0x002B with correct SCS -> o_frame_err; size=0x002A -> o_frame_valid.
REQ-036 Assert rst at byte 30, release, send a full valid frame -> no pulse during reset, then o_frame_valid for the new frame.

Source files
------------

// File: rtl/mhp_pkg.sv
// MHP frame layout shared by the receiver and transmitter.
// Byte offsets, frame sizes and receiver state encodings.
package mhp_pkg;

    localparam int MHP_FRAME_LEN = 51;
    localparam int PAYLOAD_BYTES = 42;

    localparam logic [5:0] OFF_DST     = 6'd0;
    localparam logic [5:0] OFF_SRC     = 6'd2;
    localparam logic [5:0] OFF_SIZE    = 6'd4;
    localparam logic [5:0] OFF_TD      = 6'd6;
    localparam logic [5:0] OFF_PAYLOAD = 6'd7;
    localparam logic [5:0] OFF_SCS     = 6'd49;
    localparam logic [5:0] OFF_LAST    = 6'd50;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/mhp_scs_accum.sv
// MHP shifted checksum: sum of byte << (k mod 4), 16-bit wrap.
// Clear restarts both the sum and the shift phase.
module mhp_scs_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_en,
    input  logic        i_clr,
    output logic [15:0] o_sum
);

    logic [15:0] sum_q, sum_d;
    logic [1:0]  sh_q, sh_d;

    // next sum and shift phase
    always_comb begin
        sum_d = sum_q;
        sh_d  = sh_q;
        if (i_clr) begin
            sum_d = '0;
            sh_d  = '0;
        end else if (i_en) begin
            sum_d = sum_q + ({8'h00, i_byte} << sh_q);
            sh_d  = sh_q + 2'd1;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            sh_q  <= '0;
        end else begin
            sum_q <= sum_d;
            sh_q  <= sh_d;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/frame_disassembly.sv
// MHP receiver: splits 51-byte frames into fields and checks SCS.
// Fields land in a shadow and are published only for good frames.
module frame_disassembly
    import mhp_pkg::*;
#(
    parameter int GAP_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   i_rdata,
    input  logic         i_rvalid,
    output logic [15:0]  o_dst,
    output logic [15:0]  o_src,
    output logic [15:0]  o_size,
    output logic         o_dir,
    output logic [6:0]   o_type,
    output logic [335:0] o_payload,
    output logic         o_frame_valid,
    output logic         o_frame_err,
    output logic         o_busy
);

    localparam int GW = $clog2(GAP_MAX + 2);

    logic [1:0]    state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   dst_q, dst_d;
    logic [15:0]   src_q, src_d;
    logic [15:0]   size_q, size_d;
    logic [7:0]    td_q, td_d;
    logic [335:0]  pl_q, pl_d;
    logic [7:0]    scs_lo_q, scs_lo_d;
    logic [15:0]   odst_q, odst_d;
    logic [15:0]   osrc_q, osrc_d;
    logic [15:0]   osize_q, osize_d;
    logic [7:0]    otd_q, otd_d;
    logic [335:0]  opl_q, opl_d;
    logic          fv_q, fv_d;
    logic          fe_q, fe_d;

    logic          accept;
    logic          good;
    logic          scs_en;
    logic          scs_clr;
    logic [15:0]   scs_sum;
    logic [5:0]    pidx;
    logic [8:0]    pbit;

    mhp_scs_accum u_scs (
        .clk    (clk),
        .rst    (rst),
        .i_byte (i_rdata),
        .i_en   (scs_en),
        .i_clr  (scs_clr),
        .o_sum  (scs_sum)
    );

    assign accept = i_rvalid && (state_q != ST_CHECK);
    assign pidx   = cnt_q - OFF_PAYLOAD;
    assign pbit   = {pidx, 3'b000};
    assign good   = (scs_sum == {i_rdata, scs_lo_q})
                 && (size_q <= 16'(PAYLOAD_BYTES));

    // byte capture into the shadow plus FSM, gap and publish logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        dst_d    = dst_q;
        src_d    = src_q;
        size_d   = size_q;
        td_d     = td_q;
        pl_d     = pl_q;
        scs_lo_d = scs_lo_q;
        odst_d   = odst_q;
        osrc_d   = osrc_q;
        osize_d  = osize_q;
        otd_d    = otd_q;
        opl_d    = opl_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        scs_en   = 1'b0;
        scs_clr  = 1'b0;

        if (accept) begin
            unique case (1'b1)
                (cnt_q == OFF_DST):          dst_d[7:0]   = i_rdata;
                (cnt_q == OFF_DST + 6'd1):   dst_d[15:8]  = i_rdata;
                (cnt_q == OFF_SRC):          src_d[7:0]   = i_rdata;
                (cnt_q == OFF_SRC + 6'd1):   src_d[15:8]  = i_rdata;
                (cnt_q == OFF_SIZE):         size_d[7:0]  = i_rdata;
                (cnt_q == OFF_SIZE + 6'd1):  size_d[15:8] = i_rdata;
                (cnt_q == OFF_TD):           td_d         = i_rdata;
                (cnt_q >= OFF_PAYLOAD
                 && cnt_q < OFF_SCS):        pl_d[pbit +: 8] = i_rdata;
                (cnt_q == OFF_SCS):          scs_lo_d     = i_rdata;
                default: ;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_rvalid) begin
                    scs_en  = 1'b1;
                    cnt_d   = 6'd1;
                    gap_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (i_rvalid) begin
                    gap_d  = '0;
                    cnt_d  = cnt_q + 6'd1;
                    scs_en = (cnt_q < OFF_SCS);
                    if (cnt_q == OFF_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                        fv_d    = good;
                        fe_d    = !good;
                        if (good) begin
                            odst_d  = dst_q;
                            osrc_d  = src_q;
                            osize_d = size_q;
                            otd_d   = td_q;
                            opl_d   = pl_q;
                        end
                    end
                end else if (gap_q == GW'(GAP_MAX)) begin
                    fe_d    = 1'b1;
                    cnt_d   = '0;
                    gap_d   = '0;
                    scs_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_CHECK: begin
                scs_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                scs_clr = 1'b1;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, shadow and published field registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            size_q   <= '0;
            td_q     <= '0;
            pl_q     <= '0;
            scs_lo_q <= '0;
            odst_q   <= '0;
            osrc_q   <= '0;
            osize_q  <= '0;
            otd_q    <= '0;
            opl_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            size_q   <= size_d;
            td_q     <= td_d;
            pl_q     <= pl_d;
            scs_lo_q <= scs_lo_d;
            odst_q   <= odst_d;
            osrc_q   <= osrc_d;
            osize_q  <= osize_d;
            otd_q    <= otd_d;
            opl_q    <= opl_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    assign o_dst         = odst_q;
    assign o_src         = osrc_q;
    assign o_size        = osize_q;
    assign o_dir         = otd_q[0];
    assign o_type        = otd_q[7:1];
    assign o_payload     = opl_q;
    assign o_frame_valid = fv_q;
    assign o_frame_err   = fe_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_disassembly.sv
// Directed bench for frame_disassembly.
// Frames are built here and SCS is computed by a local model.
module tb_frame_disassembly;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   i_rdata = 8'h00;
    logic         i_rvalid = 1'b0;
    logic [15:0]  o_dst;
    logic [15:0]  o_src;
    logic [15:0]  o_size;
    logic         o_dir;
    logic [6:0]   o_type;
    logic [335:0] o_payload;
    logic         o_frame_valid;
    logic         o_frame_err;
    logic         o_busy;

    int total = 0;
    int bad   = 0;
    int nv    = 0;
    int ne    = 0;
    int snap;

    logic [7:0] fr [51];

    frame_disassembly #(.GAP_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rdata       (i_rdata),
        .i_rvalid      (i_rvalid),
        .o_dst         (o_dst),
        .o_src         (o_src),
        .o_size        (o_size),
        .o_dir         (o_dir),
        .o_type        (o_type),
        .o_payload     (o_payload),
        .o_frame_valid (o_frame_valid),
        .o_frame_err   (o_frame_err),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (o_frame_valid) nv <= nv + 1;
        if (o_frame_err)   ne <= ne + 1;
    end

    task automatic chk(input string tag,
                       input logic [335:0] got,
                       input logic [335:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fix_scs();
        logic [15:0] s;
        s = 16'h0000;
        for (int k = 0; k < 49; k++)
            s = s + (16'(fr[k]) << (k % 4));
        fr[49] = s[7:0];
        fr[50] = s[15:8];
    endtask

    task automatic mk(input logic [15:0] d, input logic [15:0] s,
                      input logic [15:0] sz, input logic [7:0] td,
                      input logic [7:0] seed);
        fr[0] = d[7:0];
        fr[1] = d[15:8];
        fr[2] = s[7:0];
        fr[3] = s[15:8];
        fr[4] = sz[7:0];
        fr[5] = sz[15:8];
        fr[6] = td;
        for (int k = 7; k < 49; k++)
            fr[k] = (seed == 8'h00) ? 8'h00 : 8'(seed + 8'(k * 3));
        fix_scs();
    endtask

    function automatic logic [335:0] exp_pl();
        logic [335:0] r;
        r = '0;
        for (int k = 0; k < 42; k++)
            r[k*8 +: 8] = fr[7 + k];
        return r;
    endfunction

    // drive bytes 0..last, optional gap after byte gap_at, then one
    // trailing cycle (junk byte if requested) where the caller samples
    task automatic send(input int last, input int gap_at,
                        input int gap_n, input logic junk);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            i_rdata  = fr[k];
            i_rvalid = 1'b1;
            if (k == gap_at) begin
                for (int g = 0; g < gap_n; g++) begin
                    @(negedge clk);
                    i_rvalid = 1'b0;
                end
            end
        end
        @(negedge clk);
        i_rvalid = junk;
        i_rdata  = 8'hFF;
    endtask

    task automatic idle();
        @(negedge clk);
        i_rvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 336'(o_busy), 336'(0));
        chk("rst_fv", 336'(o_frame_valid), 336'(0));
        chk("rst_fe", 336'(o_frame_err), 336'(0));
        chk("rst_dst", 336'(o_dst), 336'(0));
        chk("rst_pl", o_payload, '0);
        rst = 1'b1;
        idle();

        // all-zero frame
        mk(16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00);
        send(50, -1, 0, 1'b0);
        chk("zero_fv", 336'(o_frame_valid), 336'(1));
        chk("zero_fe", 336'(o_frame_err), 336'(0));
        chk("zero_busy", 336'(o_busy), 336'(1));
        chk("zero_size", 336'(o_size), 336'(0));
        idle();
        chk("zero_fv_off", 336'(o_frame_valid), 336'(0));
        chk("zero_idle", 336'(o_busy), 336'(0));

        // dst=1, src=8000, hand SCS 0x0401
        mk(16'h0001, 16'h8000, 16'h0000, 8'h00, 8'h00);
        fr[49] = 8'h01;
        fr[50] = 8'h04;
        send(50, -1, 0, 1'b0);
        chk("hand_fv", 336'(o_frame_valid), 336'(1));
        chk("hand_dst", 336'(o_dst), 336'(16'h0001));
        chk("hand_src", 336'(o_src), 336'(16'h8000));
        idle();

        // corrupt SCS high byte
        fr[50] = 8'h05;
        send(50, -1, 0, 1'b0);
        chk("bad_fe", 336'(o_frame_err), 336'(1));
        chk("bad_fv", 336'(o_frame_valid), 336'(0));
        chk("bad_hold_dst", 336'(o_dst), 336'(16'h0001));
        chk("bad_hold_src", 336'(o_src), 336'(16'h8000));
        idle();

        // 4 idle cycles inside the frame are tolerated
        mk(16'h1234, 16'hABCD, 16'h0020, {7'h35, 1'b1}, 8'h11);
        send(50, 20, 4, 1'b0);
        chk("gap4_fv", 336'(o_frame_valid), 336'(1));
        chk("gap4_dst", 336'(o_dst), 336'(16'h1234));
        chk("gap4_src", 336'(o_src), 336'(16'hABCD));
        chk("gap4_size", 336'(o_size), 336'(16'h0020));
        chk("gap4_type", 336'(o_type), 336'(7'h35));
        chk("gap4_dir", 336'(o_dir), 336'(1));
        chk("gap4_pl", o_payload, exp_pl());
        idle();

        // 5 idle cycles time out
        send(20, 20, 5, 1'b0);
        chk("gap5_fe", 336'(o_frame_err), 336'(1));
        chk("gap5_busy", 336'(o_busy), 336'(0));
        chk("gap5_hold", 336'(o_dst), 336'(16'h1234));
        idle();

        // next frame after timeout, size at limit 42
        mk(16'h0BEE, 16'h0F00, 16'h002A, 8'h02, 8'h5A);
        send(50, -1, 0, 1'b0);
        chk("after_fv", 336'(o_frame_valid), 336'(1));
        chk("after_dst", 336'(o_dst), 336'(16'h0BEE));
        chk("size42", 336'(o_size), 336'(16'h002A));
        chk("after_pl", o_payload, exp_pl());
        idle();

        // size 43 with correct SCS is rejected
        mk(16'h4321, 16'h0F00, 16'h002B, 8'h02, 8'h5A);
        send(50, -1, 0, 1'b0);
        chk("size43_fe", 336'(o_frame_err), 336'(1));
        chk("size43_fv", 336'(o_frame_valid), 336'(0));
        chk("size43_hold", 336'(o_size), 336'(16'h002A));
        idle();

        // byte offered during CHECK is dropped
        mk(16'hCAFE, 16'h0102, 16'h0005, 8'h81, 8'h33);
        send(50, -1, 0, 1'b1);
        chk("junk_fv", 336'(o_frame_valid), 336'(1));
        mk(16'hD00D, 16'h0304, 16'h0007, 8'h44, 8'h77);
        send(50, -1, 0, 1'b0);
        chk("b2b_fv", 336'(o_frame_valid), 336'(1));
        chk("b2b_dst", 336'(o_dst), 336'(16'hD00D));
        idle();

        // reset mid-frame
        mk(16'h7777, 16'h8888, 16'h0010, 8'h10, 8'h99);
        snap = nv + ne;
        send(29, -1, 0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstm_busy", 336'(o_busy), 336'(0));
        chk("rstm_dst", 336'(o_dst), 336'(0));
        chk("rstm_nopulse", 336'(nv + ne - snap), 336'(0));
        rst = 1'b1;
        idle();
        send(50, -1, 0, 1'b0);
        chk("rstm_fv", 336'(o_frame_valid), 336'(1));
        chk("rstm_new_dst", 336'(o_dst), 336'(16'h7777));
        chk("rstm_new_src", 336'(o_src), 336'(16'h8888));
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
